flow_table_writer: RTL

- Control-plane writer for the exact-match flow table that the packet-path matcher reads.
- Takes one (key, value) pair and hashes the zero-padded key through an external hash unit handshake.
- Writes the key words and then the value words into the table memory at `logic_start_addr + hash * logic_entry_len`.
- The word layout is identical to the one the matcher reads back: key words first, then value words, at consecutive +4 addresses.

---
 rtl/flow_table_writer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/flow_table_writer.sv
// Control-plane writer for the exact-match flow table: hashes a (key, value) pair
// through an external hash unit, then writes key words followed by value words.
module flow_table_writer #(
  parameter int MAX_KEY_LEN = 8,
  parameter int MAX_VAL_LEN = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we_i,
  input  logic [5:0]               cfg_key_len_i,
  input  logic [5:0]               cfg_val_len_i,
  input  logic [31:0]              cfg_entry_len_i,
  input  logic [31:0]              cfg_start_addr_i,
  input  logic                     start_i,
  input  logic [MAX_KEY_LEN*8-1:0] key_i,
  input  logic [MAX_VAL_LEN*8-1:0] val_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic                     hash_start_o,
  output logic [MAX_KEY_LEN*8-1:0] hash_key_o,
  input  logic                     hash_ready_i,
  input  logic [31:0]              hash_val_i,
  output logic                     mem_ce_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [3:0]               mem_width_o,
  output logic [DATA_W-1:0]        mem_data_o
);

  localparam int KEY_W     = MAX_KEY_LEN * 8;
  localparam int VAL_W     = MAX_VAL_LEN * 8;
  localparam int KEY_WORDS = KEY_W / DATA_W;
  localparam int VAL_WORDS = VAL_W / DATA_W;

  typedef enum logic [2:0] {IDLE, HASH, WR_KEY, WR_VAL, DONE} state_e;

  state_e state_q, state_d;

  logic [5:0]        cfg_key_len_q, cfg_val_len_q;
  logic [31:0]       cfg_entry_len_q, cfg_start_addr_q;
  logic [KEY_W-1:0]  key_q, key_masked;
  logic [VAL_W-1:0]  val_q;
  logic              err_q, hash_start_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        word_idx_q;

  logic cfg_valid, start_ok, last_key, last_val;

  assign cfg_valid = (cfg_key_len_q != 6'd0) && (cfg_key_len_q <= 6'(MAX_KEY_LEN)) &&
                     (cfg_key_len_q[1:0] == 2'b00) &&
                     (cfg_val_len_q != 6'd0) && (cfg_val_len_q <= 6'(MAX_VAL_LEN)) &&
                     (cfg_val_len_q[1:0] == 2'b00);

  // A config write in the same cycle wins over a start request.
  assign start_ok = (state_q == IDLE) && start_i && !cfg_we_i;
  assign last_key = (word_idx_q == cfg_key_len_q[5:2] - 4'd1);
  assign last_val = (word_idx_q == cfg_val_len_q[5:2] - 4'd1);

  // Bytes beyond key_len are zeroed so the hash sees a canonical padded key.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    key_masked = '0;
    for (int i = 0; i < MAX_KEY_LEN; i++) begin
      if (6'(i) < cfg_key_len_q) key_masked[KEY_W-1-8*i -: 8] = key_i[KEY_W-1-8*i -: 8];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = cfg_valid ? HASH : DONE;
      HASH:    if (hash_ready_i) state_d = WR_KEY;
      WR_KEY:  if (last_key) state_d = WR_VAL;
      WR_VAL:  if (last_val) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_key_len_q    <= '0;
      cfg_val_len_q    <= '0;
      cfg_entry_len_q  <= '0;
      cfg_start_addr_q <= '0;
      key_q            <= '0;
      val_q            <= '0;
      err_q            <= 1'b0;
      hash_start_q     <= 1'b0;
      addr_q           <= '0;
      word_idx_q       <= '0;
    end else begin
      hash_start_q <= 1'b0;
      if ((state_q == IDLE) && cfg_we_i) begin
        cfg_key_len_q    <= cfg_key_len_i;
        cfg_val_len_q    <= cfg_val_len_i;
        cfg_entry_len_q  <= cfg_entry_len_i;
        cfg_start_addr_q <= cfg_start_addr_i;
      end
      if (start_ok) begin
        err_q <= !cfg_valid;
        if (cfg_valid) begin
          key_q        <= key_masked;
          val_q        <= val_i;
          hash_start_q <= 1'b1;
        end
      end
      case (state_q)
        HASH: if (hash_ready_i) begin
          addr_q     <= ADDR_W'(cfg_start_addr_q + hash_val_i * cfg_entry_len_q);
          word_idx_q <= '0;
        end
        WR_KEY: begin
          addr_q     <= addr_q + ADDR_W'(4);
          word_idx_q <= last_key ? 4'd0 : word_idx_q + 4'd1;
        end
        WR_VAL: begin
          addr_q     <= addr_q + ADDR_W'(4);
          word_idx_q <= last_val ? 4'd0 : word_idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o       = (state_q == HASH) || (state_q == WR_KEY) || (state_q == WR_VAL);
    done_o       = (state_q == DONE);
    error_o      = (state_q == DONE) && err_q;
    mem_ce_o     = (state_q == WR_KEY) || (state_q == WR_VAL);
    mem_we_o     = mem_ce_o;
    mem_addr_o   = addr_q;
    mem_width_o  = 4'd4;
    hash_start_o = hash_start_q;
    hash_key_o   = key_q;
    mem_data_o   = '0;
    // Word n carries bytes 4n..4n+3 with the lowest-index byte in the MSBs.
    if (state_q == WR_KEY) begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (word_idx_q == 4'(i)) mem_data_o = key_q[KEY_W-1-DATA_W*i -: DATA_W];
      end
    end else if (state_q == WR_VAL) begin
      for (int i = 0; i < VAL_WORDS; i++) begin
        if (word_idx_q == 4'(i)) mem_data_o = val_q[VAL_W-1-DATA_W*i -: DATA_W];
      end
    end
  end

endmodule
